// File: rtl/gelato_ram_pkg.sv
// Shared types for the gelato RAM port arbiter: requester ids and the muxed RAM request.
package gelato_ram_pkg;

  localparam int GELATO_REQ_NUM         = 4;
  localparam int GELATO_ADDR_WIDTH      = 32;
  localparam int GELATO_DATA_WIDTH      = 32;
  localparam int GELATO_MAX_OUTSTANDING = 4;

  localparam int REQ_ID_W = $clog2(GELATO_REQ_NUM);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic                         we;
    logic [GELATO_ADDR_WIDTH-1:0] addr;
    logic [GELATO_DATA_WIDTH-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/gelato_tag_fifo.sv
// In-order FIFO of requester ids, one entry per request accepted by the RAM.
module gelato_tag_fifo
  import gelato_ram_pkg::*;
#(
  parameter int DEPTH = GELATO_MAX_OUTSTANDING
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  req_id_t                    push_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output req_id_t                    head
);

  localparam int PTR_W = $clog2(DEPTH);

  req_id_t          r_mem [DEPTH];
  logic [PTR_W:0]   r_wr;
  logic [PTR_W:0]   r_rd;
  logic             w_push;
  logic             w_pop;

  // Pointers carry an extra MSB so full and empty differ only in that bit.
  assign count = r_wr - r_rd;
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (r_wr == r_rd);
  assign head  = r_mem[r_rd[PTR_W-1:0]];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + (PTR_W+1)'(1);
      end
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[PTR_W-1:0]] <= push_id;
    end
  end

endmodule

// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among REQ_NUM requesters, with in-order
// response routing through a tag FIFO.
module gelato_ram_arbiter
  import gelato_ram_pkg::*;
#(
  parameter int REQ_NUM         = GELATO_REQ_NUM,
  parameter int ADDR_WIDTH      = GELATO_ADDR_WIDTH,
  parameter int DATA_WIDTH      = GELATO_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = GELATO_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic [REQ_NUM-1:0]               req_valid,
  output logic [REQ_NUM-1:0]               req_ready,
  input  logic [REQ_NUM-1:0]               req_we,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_wdata,
  output logic [REQ_NUM-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             ram_req_valid,
  input  logic                             ram_req_ready,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic                             ram_resp_valid,
  input  logic [DATA_WIDTH-1:0]            ram_resp_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_unexpected_resp
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  req_id_t          r_rr_ptr;
  logic             r_locked;
  req_id_t          r_locked_idx;
  logic             r_err;

  req_id_t          w_hi_sel;
  req_id_t          w_lo_sel;
  logic             w_hit_hi;
  logic             w_hit_lo;
  req_id_t          w_rr_sel;
  req_id_t          w_sel;
  req_id_t          w_next_ptr;
  ram_req_t         w_req_sel;
  logic             w_ram_req_valid;
  logic             w_hs;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  req_id_t          w_head;

  // Round-robin search: lowest valid index at or above the pointer, else lowest overall.
  always_comb begin
    w_hi_sel = r_rr_ptr;
    w_lo_sel = r_rr_ptr;
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      w_hi_sel = (req_valid[i] && (req_id_t'(i) >= r_rr_ptr)) ? req_id_t'(i) : w_hi_sel;
      w_hit_hi = w_hit_hi | (req_valid[i] && (req_id_t'(i) >= r_rr_ptr));
      w_lo_sel = req_valid[i] ? req_id_t'(i) : w_lo_sel;
      w_hit_lo = w_hit_lo | req_valid[i];
    end
    if (w_hit_hi) begin
      w_rr_sel = w_hi_sel;
    end else if (w_hit_lo) begin
      w_rr_sel = w_lo_sel;
    end else begin
      w_rr_sel = r_rr_ptr;
    end
  end

  assign w_sel      = r_locked ? r_locked_idx : w_rr_sel;
  assign w_next_ptr = (w_sel == req_id_t'(REQ_NUM - 1)) ? '0 : w_sel + req_id_t'(1);

  // Payload mux from the selected requester.
  always_comb begin
    w_req_sel = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (req_id_t'(i) == w_sel) begin
        w_req_sel.we    = req_we[i];
        w_req_sel.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_req_sel.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_req_sel = w_req_sel;
      end
    end
  end

  // A held (locked) request stays presented even if rdy drops or the FIFO fills.
  assign w_ram_req_valid = r_locked | (rdy & ~w_fifo_full & (|req_valid));
  assign w_hs            = w_ram_req_valid & ram_req_ready;
  assign w_pop           = ram_resp_valid & ~w_fifo_empty;

  assign ram_req_valid       = w_ram_req_valid;
  assign ram_we              = w_ram_req_valid & w_req_sel.we;
  assign ram_addr            = w_ram_req_valid ? w_req_sel.addr : '0;
  assign ram_wdata           = w_ram_req_valid ? w_req_sel.wdata : '0;
  assign resp_rdata          = w_pop ? ram_resp_rdata : '0;
  assign outstanding         = w_count;
  assign err_unexpected_resp = r_err;

  // One-hot grant and response strobes.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (w_hs) begin
      req_ready[w_sel] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (w_pop) begin
      resp_valid[w_head] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  // Round-robin pointer, presentation lock and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_locked     <= 1'b0;
      r_locked_idx <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= w_next_ptr;
        r_locked <= 1'b0;
      end else if (w_ram_req_valid) begin
        r_locked     <= 1'b1;
        r_locked_idx <= w_sel;
      end
      if (ram_resp_valid && w_fifo_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  gelato_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_hs),
    .pop     (w_pop),
    .push_id (w_sel),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_count),
    .head    (w_head)
  );

endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// Self-checking bench for gelato_ram_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_gelato_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              ram_req_valid;
  logic              ram_req_ready;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_resp_valid;
  logic [DW-1:0]     ram_resp_rdata;
  logic [2:0]        outstanding;
  logic              err_unexpected_resp;

  gelato_ram_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rdy                 (rdy),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .ram_req_valid       (ram_req_valid),
    .ram_req_ready       (ram_req_ready),
    .ram_we              (ram_we),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_resp_valid      (ram_resp_valid),
    .ram_resp_rdata      (ram_resp_rdata),
    .outstanding         (outstanding),
    .err_unexpected_resp (err_unexpected_resp)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_rr = 0;
  bit          m_locked = 1'b0;
  int          m_lidx = 0;
  int          m_tags[$];
  logic [31:0] m_data[$];
  bit          m_err = 1'b0;
  logic [31:0] ram_q[$];

  // Expectations for the current cycle
  bit          e_valid, e_hs, e_pop;
  int          e_sel;
  logic [3:0]  e_ready, e_resp;
  logic [31:0] e_addr, e_wdata, e_rdata, cap_addr;
  logic        e_we;

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic predict();
    #1;
    e_valid = m_locked || (rdy && (m_tags.size() < MO) && (req_valid != 4'b0000));
    if (m_locked) begin
      e_sel = m_lidx;
    end else begin
      e_sel = m_rr;
      for (int k = N - 1; k >= 0; k--) if (req_valid[(m_rr + k) % N]) e_sel = (m_rr + k) % N;
    end
    e_hs    = e_valid && ram_req_ready;
    e_ready = e_hs ? (4'b0001 << e_sel) : 4'b0000;
    e_addr  = e_valid ? req_addr[e_sel*AW +: AW] : 32'h0;
    e_wdata = e_valid ? req_wdata[e_sel*DW +: DW] : 32'h0;
    e_we    = e_valid ? req_we[e_sel] : 1'b0;
    e_pop   = ram_resp_valid && (m_tags.size() > 0);
    e_resp  = e_pop ? (4'b0001 << m_tags[0]) : 4'b0000;
    e_rdata = e_pop ? m_data[0] : 32'h0;
    cap_addr = ram_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_rr = 0; m_locked = 1'b0; m_err = 1'b0;
      m_tags.delete(); m_data.delete();
    end else begin
      if (ram_resp_valid && m_tags.size() == 0) m_err = 1'b1;
      if (e_pop) begin
        void'(m_tags.pop_front());
        void'(m_data.pop_front());
      end
      if (e_hs) begin
        m_tags.push_back(e_sel);
        m_data.push_back(ram_data(req_addr[e_sel*AW +: AW]));
        ram_q.push_back(ram_data(cap_addr));
        m_rr = (e_sel + 1) % N;
        m_locked = 1'b0;
      end else if (e_valid) begin
        m_locked = 1'b1;
        m_lidx = e_sel;
      end
    end
    #1;
  endtask

  // Bench-side fake RAM: returns queued responses in order when enabled.
  task automatic set_resp(input bit en);
    if (en && ram_q.size() > 0) begin
      ram_resp_valid = 1'b1;
      ram_resp_rdata = ram_q.pop_front();
    end else begin
      ram_resp_valid = 1'b0;
      ram_resp_rdata = $urandom;
    end
  endtask

  task automatic drain();
    req_valid = '0; ram_req_ready = 1'b1; rdy = 1'b1;
    for (int g = 0; g < 40 && (m_tags.size() > 0 || m_locked); g++) begin
      set_resp(1'b1); predict(); tick();
    end
    ram_resp_valid = 1'b0;
    n_cmp++;
    if (outstanding !== 3'd0 || m_tags.size() != 0) begin
      n_fail++; $display("FAIL drain outstanding got %0d want 0", outstanding);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; ram_req_ready = 1'b1; ram_resp_valid = 1'b0; ram_resp_rdata = '0;
    req_valid = 4'hF; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    rst_n = 1'b1; req_valid = '0;
    predict();
    n_cmp += 5;
    if (ram_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset ram_req_valid got %b want 0", ram_req_valid); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset req_ready got %b want 0000", req_ready); end
    if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset resp_valid got %b want 0000", resp_valid); end
    if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset outstanding got %0d want 0", outstanding); end
    if (err_unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL reset err got %b want 0", err_unexpected_resp); end
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 32'h10 * i;
      req_wdata[i*DW +: DW] = $urandom;
    end
    req_we = '0; req_valid = 4'hF; rdy = 1'b1; ram_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_resp(1'b1);
      predict();
      n_cmp += 3;
      if (req_ready !== (4'b0001 << (c % N))) begin
        n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'b0001 << (c % N));
      end
      if (ram_addr !== 32'h10 * (c % N)) begin
        n_fail++; $display("FAIL rr_addr c=%0d got %h want %h", c, ram_addr, 32'h10 * (c % N));
      end
      if (c > 0 && (resp_valid !== (4'b0001 << ((c - 1) % N)) || resp_rdata !== ram_data(32'h10 * ((c - 1) % N)))) begin
        n_fail++; $display("FAIL rr_resp c=%0d got %b/%h want %b/%h", c, resp_valid, resp_rdata,
                           4'b0001 << ((c - 1) % N), ram_data(32'h10 * ((c - 1) % N)));
      end else if (c == 0 && resp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL rr_resp c=0 got %b want 0000", resp_valid);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_lock();
    req_valid = 4'b0100; ram_req_ready = 1'b0; rdy = 1'b1; set_resp(1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_valid[0] = 1'b1;
      if (c == 2) rdy = 1'b0;
      predict();
      n_cmp += 2;
      if (ram_addr !== 32'h20 || ram_req_valid !== 1'b1) begin
        n_fail++; $display("FAIL lock_hold c=%0d got v=%b addr=%h want v=1 addr=00000020", c, ram_req_valid, ram_addr);
      end
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_noready c=%0d got %b want 0000", c, req_ready); end
      tick();
    end
    ram_req_ready = 1'b1; rdy = 1'b1;
    predict();
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_accept got %b want 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    predict();
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_next got %b want 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_full();
    req_valid = 4'hF; ram_req_ready = 1'b1; rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_resp(1'b0); predict();
      n_cmp++;
      if (req_ready !== e_ready || ram_addr !== e_addr) begin
        n_fail++; $display("FAIL full_fill c=%0d got %b/%h want %b/%h", c, req_ready, ram_addr, e_ready, e_addr);
      end
      tick();
    end
    predict();
    n_cmp++;
    if (outstanding !== 3'd4 || ram_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_block got out=%0d v=%b want out=4 v=0", outstanding, ram_req_valid);
    end
    tick();
    set_resp(1'b1); predict();
    n_cmp++;
    if (ram_req_valid !== 1'b0 || req_ready !== 4'b0000 || resp_valid !== e_resp || resp_valid === 4'b0000) begin
      n_fail++; $display("FAIL full_pop got v=%b rdy=%b resp=%b want v=0 rdy=0000 resp=%b", ram_req_valid, req_ready, resp_valid, e_resp);
    end
    tick();
    set_resp(1'b0); predict();
    n_cmp++;
    if (ram_req_valid !== 1'b1 || req_ready !== e_ready || outstanding !== 3'd3) begin
      n_fail++; $display("FAIL full_regrant got v=%b rdy=%b out=%0d want v=1 rdy=%b out=3", ram_req_valid, req_ready, outstanding, e_ready);
    end
    tick();
  endtask

  task automatic test_rdy_low();
    rdy = 1'b0; req_valid = 4'hF; ram_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_resp(1'b1); predict();
      n_cmp++;
      if (ram_req_valid !== 1'b0 || resp_valid !== e_resp || resp_rdata !== e_rdata || e_resp === 4'b0000) begin
        n_fail++; $display("FAIL rdy_low c=%0d got v=%b resp=%b/%h want v=0 resp=%b/%h", c, ram_req_valid, resp_valid, resp_rdata, e_resp, e_rdata);
      end
      tick();
    end
    rdy = 1'b1; set_resp(1'b0); predict();
    n_cmp++;
    if (req_ready !== (4'b0001 << m_rr) || outstanding !== 3'd0) begin
      n_fail++; $display("FAIL rdy_resume got %b out=%0d want %b out=0", req_ready, outstanding, 4'b0001 << m_rr);
    end
    tick();
    drain();
  endtask

  task automatic test_unexpected();
    req_valid = '0; ram_resp_valid = 1'b1; ram_resp_rdata = $urandom;
    predict();
    n_cmp++;
    if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL unexp_strobe got %b want 0000", resp_valid); end
    tick();
    ram_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      predict();
      n_cmp++;
      if (err_unexpected_resp !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky c=%0d got %b want 1", c, err_unexpected_resp); end
      tick();
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    predict();
    n_cmp++;
    if (err_unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL unexp_clear got %b want 0", err_unexpected_resp); end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0011; ram_req_ready = 1'b1; rdy = 1'b1; set_resp(1'b0);
    predict(); tick(); predict(); tick();
    req_valid = '0; predict();
    n_cmp++;
    if (outstanding !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre got %0d want 2", outstanding); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    predict();
    n_cmp++;
    if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rstmid_out got %0d want 0", outstanding); end
    set_resp(1'b1); predict();
    n_cmp++;
    if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_strobe got %b want 0000", resp_valid); end
    tick();
    ram_resp_valid = 1'b0; predict();
    n_cmp++;
    if (err_unexpected_resp !== 1'b1) begin n_fail++; $display("FAIL rstmid_err got %b want 1", err_unexpected_resp); end
    ram_q.delete();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_random();
    bit [N-1:0] pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_we[i] = ($urandom_range(0, 1) == 1);
          req_addr[i*AW +: AW] = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      ram_req_ready = ($urandom_range(0, 2) != 0);
      set_resp($urandom_range(0, 1) == 1);
      predict();
      n_cmp++;
      if (ram_req_valid !== e_valid || ram_addr !== e_addr || ram_we !== e_we || ram_wdata !== e_wdata ||
          req_ready !== e_ready || resp_valid !== e_resp || (e_pop && resp_rdata !== e_rdata) ||
          outstanding !== 3'(m_tags.size()) || err_unexpected_resp !== m_err) begin
        n_fail++;
        $display("FAIL random cyc=%0d got v=%b a=%h we=%b wd=%h rdy=%b resp=%b rd=%h out=%0d err=%b want v=%b a=%h we=%b wd=%h rdy=%b resp=%b rd=%h out=%0d err=%b",
                 cyc, ram_req_valid, ram_addr, ram_we, ram_wdata, req_ready, resp_valid, resp_rdata, outstanding, err_unexpected_resp,
                 e_valid, e_addr, e_we, e_wdata, e_ready, e_resp, e_rdata, m_tags.size(), m_err);
      end
      tick();
      for (int i = 0; i < N; i++) pend[i] = req_valid[i] && !(e_hs && e_sel == i);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_rdy_low();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
